// File: rtl/cpu_pkg.sv
// Shared CPU constants: architectural PC width, instruction size and reset vector.
package cpu_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_full;

  assign w_full = &r_q;
  assign q      = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && !w_full) begin
      r_q <= r_q + W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register and next-PC mux, with an ID->EX recovery PC for mispredict repair,
// pipeline flush generation and saturating branch statistics.
module pc_fetch_ctrl #(
  parameter int unsigned       XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(cpu_pkg::RESET_PC),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              id_branch,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_target,
  input  logic              pred,
  input  logic              ex_branch,
  input  logic              fail,
  output logic [XLEN-1:0]   pc_o,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic              rec_err
);

  import cpu_pkg::*;

  localparam logic [XLEN-1:0] Step = XLEN'(INSN_BYTES);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ex_rec_pc;
  logic            r_ex_rec_valid;
  logic            r_rec_err;

  logic [XLEN-1:0] w_next_pc;
  logic            w_take;
  logic            w_capture;

  // A predicted-taken branch is only acted on when it actually leaves ID this cycle.
  assign w_take    = pred & id_branch & ~stall;
  assign w_capture = id_branch & ~stall & ~fail;

  always_comb begin
    w_next_pc = r_pc + Step;
    if (fail) begin
      w_next_pc = r_ex_rec_pc;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (pred && id_branch) begin
      w_next_pc = id_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Recovery PC is the path the predictor did not choose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rec_pc    <= '0;
      r_ex_rec_valid <= 1'b0;
    end else begin
      r_ex_rec_valid <= w_capture;
      if (w_capture) begin
        r_ex_rec_pc <= pred ? (id_pc + Step) : id_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rec_err <= 1'b0;
    end else if (fail && !r_ex_rec_valid) begin
      r_rec_err <= 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ex_branch),
    .q   (branch_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_mispred_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fail),
    .q   (mispred_cnt)
  );

  assign pc_o        = r_pc;
  assign id_ex_flush = fail;
  assign if_id_flush = fail | w_take;
  assign rec_err     = r_rec_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed table-driven bench for pc_fetch_ctrl plus hand-written reset and saturation sequences.
module tb_pc_fetch_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              id_branch;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_target;
  logic              pred;
  logic              ex_branch;
  logic              fail;
  logic [XLEN-1:0]   pc_o;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;
  logic              rec_err;

  int checks;
  int failures;

  pc_fetch_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .id_branch   (id_branch),
    .id_pc       (id_pc),
    .id_target   (id_target),
    .pred        (pred),
    .ex_branch   (ex_branch),
    .fail        (fail),
    .pc_o        (pc_o),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt),
    .rec_err     (rec_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        id_branch;
    logic [31:0] id_pc;
    logic [31:0] id_target;
    logic        pred;
    logic        ex_branch;
    logic        fail;
    logic        exp_if_flush;
    logic        exp_id_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_bcnt;
    logic [31:0] exp_mcnt;
    logic        exp_rec_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic st, logic ib, logic [31:0] ipc, logic [31:0] tgt, logic pr,
                              logic eb, logic fl, logic eif, logic eid, logic [31:0] epc,
                              logic [31:0] eb_cnt, logic [31:0] em_cnt, logic err);
    vec_t v;
    v.stall = st; v.id_branch = ib; v.id_pc = ipc; v.id_target = tgt; v.pred = pr;
    v.ex_branch = eb; v.fail = fl; v.exp_if_flush = eif; v.exp_id_flush = eid;
    v.exp_pc = epc; v.exp_bcnt = eb_cnt; v.exp_mcnt = em_cnt; v.exp_rec_err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; id_branch = 0; id_pc = '0; id_target = '0; pred = 0; ex_branch = 0; fail = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //        st ib id_pc        target       pr eb fl  if id  pc_next      bc mc err
    vecs[0]  = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'h4,       0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'h8,       0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'hC,       0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'h10,      0, 0, 0);
    vecs[4]  = mk(0, 1, 32'h20,    32'h80,      1, 0, 0, 1, 0, 32'h80,      0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,     32'h0,       0, 1, 0, 0, 0, 32'h84,      1, 0, 0);
    vecs[6]  = mk(0, 1, 32'h84,    32'h100,     0, 0, 0, 0, 0, 32'h88,      1, 0, 0);
    vecs[7]  = mk(0, 0, 32'h0,     32'h0,       0, 1, 1, 1, 1, 32'h100,     2, 1, 0);
    vecs[8]  = mk(1, 1, 32'h104,   32'h200,     1, 0, 0, 0, 0, 32'h100,     2, 1, 0);
    vecs[9]  = mk(0, 1, 32'h104,   32'h200,     1, 0, 0, 1, 0, 32'h200,     2, 1, 0);
    vecs[10] = mk(1, 1, 32'h300,   32'h400,     1, 1, 1, 1, 1, 32'h108,     3, 2, 0);
    vecs[11] = mk(0, 0, 32'h0,     32'h0,       0, 1, 1, 1, 1, 32'h108,     4, 3, 1);
    vecs[12] = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'h10C,     4, 3, 1);
    vecs[13] = mk(0, 1, 32'h10C,   32'hFFFF_FFFC, 1, 0, 0, 1, 0, 32'hFFFF_FFFC, 4, 3, 1);
    vecs[14] = mk(0, 0, 32'h0,     32'h0,       0, 0, 0, 0, 0, 32'h0,       4, 3, 1);

    idle_inputs();
    rst = 1;
    step();
    step();
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_bcnt", 32'(branch_cnt), 32'h0);
    chk("reset_mcnt", 32'(mispred_cnt), 32'h0);
    chk("reset_rec_err", 32'(rec_err), 32'h0);
    chk("reset_if_flush", 32'(if_id_flush), 32'h0);
    chk("reset_id_flush", 32'(id_ex_flush), 32'h0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall; id_branch = vecs[i].id_branch; id_pc = vecs[i].id_pc;
      id_target = vecs[i].id_target; pred = vecs[i].pred;
      ex_branch = vecs[i].ex_branch; fail = vecs[i].fail;
      @(negedge clk);
      chk($sformatf("v%0d_if_id_flush", i), 32'(if_id_flush), 32'(vecs[i].exp_if_flush));
      chk($sformatf("v%0d_id_ex_flush", i), 32'(id_ex_flush), 32'(vecs[i].exp_id_flush));
      step();
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      chk($sformatf("v%0d_branch_cnt", i), 32'(branch_cnt), vecs[i].exp_bcnt);
      chk($sformatf("v%0d_mispred_cnt", i), 32'(mispred_cnt), vecs[i].exp_mcnt);
      chk($sformatf("v%0d_rec_err", i), 32'(rec_err), 32'(vecs[i].exp_rec_err));
    end

    // Asynchronous reset mid-cycle with redirect requests active.
    id_branch = 1; pred = 1; id_target = 32'h500; fail = 1; ex_branch = 1;
    step();
    #2;
    rst = 1;
    #1;
    chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_bcnt", 32'(branch_cnt), 32'h0);
    chk("async_rst_mcnt", 32'(mispred_cnt), 32'h0);
    chk("async_rst_rec_err", 32'(rec_err), 32'h0);
    step();
    chk("rst_hold_pc", pc_o, 32'h0);
    chk("rst_hold_mcnt", 32'(mispred_cnt), 32'h0);
    idle_inputs();
    rst = 0;

    // Saturation: all-ones for CNT_W is 15.
    fail = 1; ex_branch = 1;
    for (int i = 0; i < 15; i++) step();
    chk("sat_mcnt_full", 32'(mispred_cnt), 32'hF);
    step();
    chk("sat_mcnt_hold", 32'(mispred_cnt), 32'hF);
    chk("sat_bcnt_hold", 32'(branch_cnt), 32'hF);
    chk("sat_rec_err", 32'(rec_err), 32'h1);
    idle_inputs();
    step();
    chk("sat_mcnt_idle", 32'(mispred_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage PC controller sitting directly downstream of the 2-bit branch predictor. It consumes the predictor's ID-stage `pred` and EX-stage `fail` signals and owns the fetch PC register. It carries a recovery PC from ID to EX so a misprediction can be repaired, generates the IF/ID and ID/EX flushes, and keeps saturating branch statistics.

## Interface
- `XLEN`, 32: PC width.
- `RESET_PC`, 0: fetch PC after reset.
- `CNT_W`, 16: statistics counter width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard-unit stall; holds the PC and the IF/ID register.
- `id_branch` in 1: instruction in ID is a conditional branch.
- `id_pc` in XLEN: PC of the ID instruction.
- `id_target` in XLEN: branch target computed in ID.
- `pred` in 1: predictor's take decision for the ID branch.
- `ex_branch` in 1: instruction in EX is a branch, resolved this cycle.
- `fail` in 1: EX branch mispredicted.
- `pc_o` out XLEN: current fetch PC to instruction memory.
- `if_id_flush` out 1: squash the IF/ID register.
- `id_ex_flush` out 1: squash the ID/EX register.
- `branch_cnt` out CNT_W: resolved branches, saturating.
- `mispred_cnt` out CNT_W: mispredictions, saturating.
- `rec_err` out 1: sticky flag, set when `fail` arrives with no valid recovery entry.

## Operation
- Next-PC priority: `fail` > `stall` > (`pred` & `id_branch`) > sequential.
  - `fail`: next PC = `ex_rec_pc`.
  - `stall`: hold `pc_o`.
  - predicted taken: next PC = `id_target`.
  - otherwise: next PC = `pc_o + 4`.
- Recovery register (`ex_rec_pc`, `ex_rec_valid`) models the ID→EX hop.
  - Capture when `id_branch & ~stall & ~fail`.
  - Captured value is `id_pc + 4` if `pred` is 1, else `id_target`.
  - `ex_rec_valid` is cleared when `stall` or `fail` is high, or when `id_branch` is 0 (a bubble or non-branch enters EX).
- Flushes (combinational):
  - `id_ex_flush = fail`.
  - `if_id_flush = fail | (pred & id_branch & ~stall)`.
- `fail` overrides `pred` in the same cycle: the ID instruction is wrong-path and is flushed, and no recovery entry is captured.
- `pred` during `stall`: no action. The branch stays in ID and is re-evaluated on the first unstalled cycle.
- Counters:
  - `branch_cnt` increments on `ex_branch`.
  - `mispred_cnt` increments on `fail`.
  - Both hold at all-ones, with no wrap.
- `fail & ~ex_rec_valid` sets `rec_err`. The redirect still uses the stale `ex_rec_pc`. `rec_err` clears only on reset.
- PC arithmetic is modulo 2^XLEN: `pc_o + 4` wraps silently at the top of the address space.

## Timing
- Reset values:
  - `pc_o = RESET_PC`.
  - `ex_rec_pc = 0`, `ex_rec_valid = 0`.
  - Both counters 0, `rec_err = 0`.
  - Flush outputs follow their inputs; with inputs low they are 0.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of any `fail` or `pred` in that cycle.
- Latencies:
  - `pred` in cycle n → `pc_o = id_target` in cycle n+1. Penalty is 1 bubble.
  - `fail` in cycle n → `pc_o = ex_rec_pc` in cycle n+1. Penalty is 2 bubbles.
- Recovery entry captured in cycle n is consumed by `fail` in cycle n+1.
- Counters update on the clock edge after the event.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `INSN_BYTES = 4`, `RESET_PC` default.
- One sub-module `sat_counter` (parameter `W`, inputs `clk`, `rst`, `inc`, output `q`), instantiated twice for the statistics counters.
- Recovery register, PC register, and next-PC mux live in the top level.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `pc_o = RESET_PC`, counters 0, `rec_err = 0`, before the next edge.
- Sequential fetch: no branches for 4 cycles from 0 → `pc_o` = 0, 4, 8, 12, 16.
- Predicted taken, correct:
  - Stimulus: `id_branch = 1`, `pred = 1`, `id_pc = 0x20`, `id_target = 0x80`.
  - Response: `if_id_flush = 1`; next `pc_o = 0x80`; `ex_rec_pc = 0x24`.
  - Then `ex_branch = 1`, `fail = 0` → `branch_cnt = 1`.
- Mispredict recovery:
  - Stimulus: `pred = 0`, `id_target = 0x100`, then `fail = 1` with `ex_branch = 1`.
  - Response: both flushes = 1; next `pc_o = 0x100`; `mispred_cnt = 1`.
- Simultaneous and stall cases:
  - `stall = 1` with `pred = 1` → PC held, `if_id_flush = 0`.
  - `fail = 1` with `stall = 1` and `pred = 1` → redirect to `ex_rec_pc`, no recovery capture.
- Saturation and error:
  - Preload counters to 0xFFFF, then fire `fail` → counter stays 0xFFFF.
  - `fail` with `ex_rec_valid = 0` → `rec_err = 1` until reset.
